// File: rtl/demo_slave_responder_if.sv
// Request/response bundle between a bus master and the demo slave responder.
// The master drives the request fields and the slave drives the handshake and response.
interface demo_slave_responder_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8
);
    logic                  dev_valid;
    logic                  dev_mode;
    logic [ADDR_WIDTH-1:0] dev_addr;
    logic [DATA_WIDTH-1:0] dev_wdata;
    logic                  dev_ready;
    logic [DATA_WIDTH-1:0] dev_rdata;
    logic                  dev_rvalid;
    logic                  addr_err;

    modport master (
        output dev_valid, dev_mode, dev_addr, dev_wdata,
        input  dev_ready, dev_rdata, dev_rvalid, addr_err
    );

    modport slave (
        input  dev_valid, dev_mode, dev_addr, dev_wdata,
        output dev_ready, dev_rdata, dev_rvalid, addr_err
    );
endinterface

// File: rtl/demo_slave_responder.sv
// Slave-side demo device: serves bus reads/writes from a local byte memory after a fixed
// number of wait states, with a read-only debug port and activity counters.
module demo_slave_responder #(
    parameter int ADDR_WIDTH     = 16,
    parameter int DATA_WIDTH     = 8,
    parameter int MEM_ADDR_WIDTH = 5,
    parameter int WAIT_CYCLES    = 2,
    parameter int CNT_WIDTH      = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    demo_slave_responder_if.slave     bus,
    input  logic [MEM_ADDR_WIDTH-1:0] dbg_addr,
    output logic [DATA_WIDTH-1:0]     dbg_rdata,
    output logic [CNT_WIDTH-1:0]      wr_count,
    output logic [CNT_WIDTH-1:0]      rd_count
);
    localparam int WCW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [WCW-1:0] WAIT_LAST = WCW'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACCESS,
        S_RESP
    } state_t;

    state_t                    state;
    logic [DATA_WIDTH-1:0]     mem [0:(2**MEM_ADDR_WIDTH)-1];
    logic                      mode_q;
    logic                      in_range_q;
    logic [MEM_ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0]     wdata_q;
    logic [WCW-1:0]            wait_cnt;
    logic                      accept;
    logic                      addr_in_range;

    assign accept        = (state == S_IDLE) && bus.dev_valid && bus.dev_ready;
    assign addr_in_range = (bus.dev_addr[ADDR_WIDTH-1:MEM_ADDR_WIDTH] == '0);

    // Request fields are captured once at accept so later bus changes cannot disturb the
    // in-flight access; outputs are all registered and the error flag fires on leaving ACCESS.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= S_IDLE;
            bus.dev_ready  <= 1'b1;
            bus.dev_rvalid <= 1'b0;
            bus.dev_rdata  <= '0;
            bus.addr_err   <= 1'b0;
            dbg_rdata      <= '0;
            wr_count       <= '0;
            rd_count       <= '0;
            wait_cnt       <= '0;
            mode_q         <= 1'b0;
            in_range_q     <= 1'b0;
            addr_q         <= '0;
            wdata_q        <= '0;
        end else begin
            dbg_rdata      <= mem[dbg_addr];
            bus.dev_rvalid <= 1'b0;
            bus.addr_err   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        mode_q        <= bus.dev_mode;
                        in_range_q    <= addr_in_range;
                        addr_q        <= bus.dev_addr[MEM_ADDR_WIDTH-1:0];
                        wdata_q       <= bus.dev_wdata;
                        wait_cnt      <= '0;
                        bus.dev_ready <= 1'b0;
                        state         <= (WAIT_CYCLES > 0) ? S_WAIT : S_ACCESS;
                    end
                end
                S_WAIT: begin
                    if (wait_cnt == WAIT_LAST) begin
                        state <= S_ACCESS;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_ACCESS: begin
                    bus.addr_err <= !in_range_q;
                    if (mode_q) begin
                        if (in_range_q) begin
                            wr_count <= wr_count + 1'b1;
                        end
                        bus.dev_ready <= 1'b1;
                        state         <= S_IDLE;
                    end else begin
                        bus.dev_rvalid <= 1'b1;
                        bus.dev_rdata  <= in_range_q ? mem[addr_q] : '0;
                        rd_count       <= rd_count + 1'b1;
                        state          <= S_RESP;
                    end
                end
                S_RESP: begin
                    bus.dev_ready <= 1'b1;
                    state         <= S_IDLE;
                end
                default: begin
                    bus.dev_ready <= 1'b1;
                    state         <= S_IDLE;
                end
            endcase
        end
    end

    // Memory contents survive reset; an access interrupted by reset never reaches this write.
    always_ff @(posedge clk) begin
        if (!rst && (state == S_ACCESS) && mode_q && in_range_q) begin
            mem[addr_q] <= wdata_q;
        end
    end
endmodule
